// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared MIPS control constants: FSM states, opcodes, ALU op codes
package mips_pkg;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_RTEX   = 4'd6,
        S_RTWB   = 4'd7,
        S_BRANCH = 4'd8,
        S_IMMEX  = 4'd9,
        S_IMMWB  = 4'd10,
        S_JUMP   = 4'd11,
        S_TRAP   = 4'd12
    } state_e;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_ANDI = 6'b001100;
    localparam logic [5:0] OP_ORI  = 6'b001101;
    localparam logic [5:0] OP_J    = 6'b000010;

    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_SUB   = 3'b001;
    localparam logic [2:0] ALU_FUNCT = 3'b010;
    localparam logic [2:0] ALU_AND   = 3'b011;
    localparam logic [2:0] ALU_OR    = 3'b100;

    localparam logic [1:0] SRCB_B     = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_IMMSH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - multi-cycle MIPS main controller FSM with retired-instruction counter
module multicycle_control
    import mips_pkg::*;
#(
    parameter int MEM_HANDSHAKE = 1,
    parameter int CNT_W         = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [5:0]       opcode,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             iord,
    output logic             mem_read,
    output logic             mem_write,
    output logic             ir_write,
    output logic             reg_dst,
    output logic             mem_to_reg,
    output logic             reg_write,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       pc_src,
    output logic [2:0]       alu_op,
    output logic             illegal,
    output logic [3:0]       state,
    output logic [CNT_W-1:0] instr_count
);

    state_e           state_q, state_d;
    logic [5:0]       op_q;
    logic             illegal_q;
    logic [CNT_W-1:0] cnt_q;
    logic             done;

    // Without the handshake every memory access is assumed to finish in one cycle.
    assign done = (MEM_HANDSHAKE != 0) ? mem_ready : 1'b1;

    assign state       = state_q;
    assign illegal     = illegal_q;
    assign instr_count = cnt_q;

    // State register, opcode latch, sticky illegal flag and retired-instruction counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_FETCH;
            op_q      <= 6'd0;
            illegal_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == S_DECODE) begin
                op_q <= opcode;
            end
            if (state_d == S_TRAP) begin
                illegal_q <= 1'b1;
            end
            if ((state_q != S_FETCH) && (state_d == S_FETCH)) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    // Next-state decode and per-state datapath controls; enables are forced off during reset.
    always_comb begin
        state_d    = state_q;
        pc_write   = 1'b0;
        iord       = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        reg_write  = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = SRCB_B;
        pc_src     = PCSRC_ALU;
        alu_op     = ALU_ADD;

        case (state_q)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = SRCB_FOUR;
                ir_write  = done;
                pc_write  = done;
                if (done) begin
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                alu_src_b = SRCB_IMMSH;
                case (opcode)
                    OP_R:                   state_d = S_RTEX;
                    OP_LW, OP_SW:           state_d = S_MEMADR;
                    OP_BEQ, OP_BNE:         state_d = S_BRANCH;
                    OP_ADDI, OP_ANDI,
                    OP_ORI:                 state_d = S_IMMEX;
                    OP_J:                   state_d = S_JUMP;
                    default:                state_d = S_TRAP;
                endcase
            end
            S_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                state_d   = (op_q == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                mem_read = 1'b1;
                iord     = 1'b1;
                if (done) begin
                    state_d = S_MEMWB;
                end
            end
            S_MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEMWR: begin
                mem_write = 1'b1;
                iord      = 1'b1;
                if (done) begin
                    state_d = S_FETCH;
                end
            end
            S_RTEX: begin
                alu_src_a = 1'b1;
                alu_op    = ALU_FUNCT;
                state_d   = S_RTWB;
            end
            S_RTWB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
                state_d   = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a = 1'b1;
                alu_op    = ALU_SUB;
                pc_src    = PCSRC_ALUOUT;
                pc_write  = ((op_q == OP_BEQ) & zero) | ((op_q == OP_BNE) & ~zero);
                state_d   = S_FETCH;
            end
            S_IMMEX: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                case (op_q)
                    OP_ANDI: alu_op = ALU_AND;
                    OP_ORI:  alu_op = ALU_OR;
                    default: alu_op = ALU_ADD;
                endcase
                state_d = S_IMMWB;
            end
            S_IMMWB: begin
                reg_write = 1'b1;
                state_d   = S_FETCH;
            end
            S_JUMP: begin
                pc_src   = PCSRC_JUMP;
                pc_write = 1'b1;
                state_d  = S_FETCH;
            end
            S_TRAP: begin
                state_d = S_TRAP;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase

        if (!rst_n) begin
            pc_write  = 1'b0;
            ir_write  = 1'b0;
            reg_write = 1'b0;
            mem_read  = 1'b0;
            mem_write = 1'b0;
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - scoreboard bench for multicycle_control against an instruction-level model
module tb_multicycle_control;

    localparam logic [5:0] T_R = 6'b000000, T_LW = 6'b100011, T_SW = 6'b101011;
    localparam logic [5:0] T_BEQ = 6'b000100, T_BNE = 6'b000101, T_ADDI = 6'b001000;
    localparam logic [5:0] T_ANDI = 6'b001100, T_ORI = 6'b001101, T_J = 6'b000010;

    localparam int P_FETCH = 0, P_DECODE = 1, P_MEMADR = 2, P_MEMRD = 3, P_MEMWB = 4;
    localparam int P_MEMWR = 5, P_RTEX = 6, P_RTWB = 7, P_BRANCH = 8, P_IMMEX = 9;
    localparam int P_IMMWB = 10, P_JUMP = 11, P_TRAP = 12;

    typedef struct packed {
        logic [3:0]  state;
        logic        pc_write;
        logic        iord;
        logic        mem_read;
        logic        mem_write;
        logic        ir_write;
        logic        reg_dst;
        logic        mem_to_reg;
        logic        reg_write;
        logic        alu_src_a;
        logic [1:0]  alu_src_b;
        logic [1:0]  pc_src;
        logic [2:0]  alu_op;
        logic        illegal;
        logic [15:0] cnt;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [5:0]  opcode = 6'd0;
    logic        zero = 1'b0;
    logic        mem_ready = 1'b0;

    logic        pc_write, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a;
    logic [1:0]  alu_src_b, pc_src;
    logic [2:0]  alu_op;
    logic        illegal;
    logic [3:0]  state;
    logic [15:0] instr_count;

    logic        b_pc_write, b_iord, b_mem_read, b_mem_write, b_ir_write, b_reg_dst, b_mem_to_reg;
    logic        b_reg_write, b_alu_src_a;
    logic [1:0]  b_alu_src_b, b_pc_src;
    logic [2:0]  b_alu_op;
    logic        b_illegal;
    logic [3:0]  b_state;
    logic [3:0]  b_instr_count;

    int   checks = 0;
    int   failures = 0;
    int   mcount = 0;
    logic mill = 1'b0;
    exp_t exp_q[$];
    exp_t mon_e, mon_a, mon_e4, mon_a4;

    always #5 clk = ~clk;

    multicycle_control #(.MEM_HANDSHAKE(1), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .pc_write(pc_write), .iord(iord), .mem_read(mem_read), .mem_write(mem_write),
        .ir_write(ir_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .pc_src(pc_src), .alu_op(alu_op),
        .illegal(illegal), .state(state), .instr_count(instr_count)
    );

    multicycle_control #(.MEM_HANDSHAKE(1), .CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .pc_write(b_pc_write), .iord(b_iord), .mem_read(b_mem_read), .mem_write(b_mem_write),
        .ir_write(b_ir_write), .reg_dst(b_reg_dst), .mem_to_reg(b_mem_to_reg), .reg_write(b_reg_write),
        .alu_src_a(b_alu_src_a), .alu_src_b(b_alu_src_b), .pc_src(b_pc_src), .alu_op(b_alu_op),
        .illegal(b_illegal), .state(b_state), .instr_count(b_instr_count)
    );

    function automatic logic rbit();
        return 1'($urandom & 1);
    endfunction

    // Expected controls for one cycle of an instruction in the given phase.
    function automatic exp_t expect_out(input int ph, input logic [5:0] op, input logic zv, input logic rdy);
        exp_t e;
        e = '0;
        e.state   = 4'(ph);
        e.illegal = mill;
        e.cnt     = 16'(mcount);
        case (ph)
            P_FETCH:  begin e.mem_read = 1; e.alu_src_b = 2'b01; e.ir_write = rdy; e.pc_write = rdy; end
            P_DECODE: e.alu_src_b = 2'b11;
            P_MEMADR: begin e.alu_src_a = 1; e.alu_src_b = 2'b10; end
            P_MEMRD:  begin e.mem_read = 1; e.iord = 1; end
            P_MEMWB:  begin e.reg_write = 1; e.mem_to_reg = 1; end
            P_MEMWR:  begin e.mem_write = 1; e.iord = 1; end
            P_RTEX:   begin e.alu_src_a = 1; e.alu_op = 3'b010; end
            P_RTWB:   begin e.reg_write = 1; e.reg_dst = 1; end
            P_BRANCH: begin
                e.alu_src_a = 1; e.alu_op = 3'b001; e.pc_src = 2'b01;
                e.pc_write  = (op == T_BEQ) ? zv : ~zv;
            end
            P_IMMEX:  begin
                e.alu_src_a = 1; e.alu_src_b = 2'b10;
                e.alu_op = (op == T_ANDI) ? 3'b011 : (op == T_ORI) ? 3'b100 : 3'b000;
            end
            P_IMMWB:  e.reg_write = 1;
            P_JUMP:   begin e.pc_src = 2'b10; e.pc_write = 1; end
            default:  ;
        endcase
        return e;
    endfunction

    // One clock slot: drive inputs, queue the expected response, advance to the next slot.
    task automatic step(input int ph, input logic [5:0] op, input logic rdy, input logic zv);
        opcode    = (ph == P_DECODE) ? op : 6'($urandom);
        mem_ready = rdy;
        zero      = zv;
        exp_q.push_back(expect_out(ph, op, zv, rdy));
        @(posedge clk); #1;
    endtask

    task automatic run_instr(input logic [5:0] op, input int fw, input int mw, input logic zb);
        for (int i = 0; i < fw; i++) step(P_FETCH, op, 1'b0, rbit());
        step(P_FETCH, op, 1'b1, rbit());
        step(P_DECODE, op, rbit(), rbit());
        case (op)
            T_R: begin step(P_RTEX, op, rbit(), rbit()); step(P_RTWB, op, rbit(), rbit()); end
            T_LW: begin
                step(P_MEMADR, op, rbit(), rbit());
                for (int i = 0; i < mw; i++) step(P_MEMRD, op, 1'b0, rbit());
                step(P_MEMRD, op, 1'b1, rbit());
                step(P_MEMWB, op, rbit(), rbit());
            end
            T_SW: begin
                step(P_MEMADR, op, rbit(), rbit());
                for (int i = 0; i < mw; i++) step(P_MEMWR, op, 1'b0, rbit());
                step(P_MEMWR, op, 1'b1, rbit());
            end
            T_BEQ, T_BNE: step(P_BRANCH, op, rbit(), zb);
            T_ADDI, T_ANDI, T_ORI: begin step(P_IMMEX, op, rbit(), rbit()); step(P_IMMWB, op, rbit(), rbit()); end
            T_J: step(P_JUMP, op, rbit(), rbit());
            default: begin
                mill = 1'b1;
                for (int i = 0; i < 10; i++) step(P_TRAP, op, rbit(), rbit());
                return;
            end
        endcase
        mcount++;
    endtask

    task automatic do_reset(input int n);
        exp_t e;
        rst_n  = 1'b0;
        mill   = 1'b0;
        mcount = 0;
        for (int i = 0; i < n; i++) begin
            opcode = 6'($urandom); mem_ready = rbit(); zero = rbit();
            e = '0;
            e.alu_src_b = 2'b01;
            exp_q.push_back(e);
            @(posedge clk); #1;
        end
        rst_n = 1'b1;
    endtask

    task automatic check(input string name, input logic ok, input int got, input int want);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s t=%0t got=%0d want=%0d", name, $time, got, want);
        end
    endtask

    // Monitor: every cycle with a queued expectation, compare both DUTs.
    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            mon_e = exp_q.pop_front();
            mon_a = {state, pc_write, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg,
                     reg_write, alu_src_a, alu_src_b, pc_src, alu_op, illegal, instr_count};
            mon_a4 = {b_state, b_pc_write, b_iord, b_mem_read, b_mem_write, b_ir_write, b_reg_dst,
                      b_mem_to_reg, b_reg_write, b_alu_src_a, b_alu_src_b, b_pc_src, b_alu_op,
                      b_illegal, 12'd0, b_instr_count};
            mon_e4 = mon_e;
            mon_e4.cnt = {12'd0, mon_e.cnt[3:0]};
            checks += 2;
            if (mon_a !== mon_e) begin
                failures++;
                $display("FAIL outputs t=%0t got=%h want=%h", $time, mon_a, mon_e);
            end
            if (mon_a4 !== mon_e4) begin
                failures++;
                $display("FAIL outputs_cnt4 t=%0t got=%h want=%h", $time, mon_a4, mon_e4);
            end
        end
    end

    initial begin
        logic [5:0] legal [9];
        legal = '{T_R, T_LW, T_SW, T_BEQ, T_BNE, T_ADDI, T_ANDI, T_ORI, T_J};
        @(posedge clk); #1;
        do_reset(3);
        run_instr(T_R, 0, 0, 1'b0);
        run_instr(T_LW, 1, 2, 1'b0);
        run_instr(T_BEQ, 0, 0, 1'b0);
        run_instr(T_BNE, 0, 0, 1'b0);
        run_instr(T_BEQ, 0, 0, 1'b1);
        run_instr(T_ANDI, 0, 0, 1'b0);
        run_instr(T_ORI, 0, 0, 1'b0);
        run_instr(T_ADDI, 2, 0, 1'b0);
        run_instr(T_SW, 0, 1, 1'b0);
        run_instr(T_J, 0, 0, 1'b0);
        for (int i = 0; i < 40; i++) begin
            run_instr(legal[$urandom_range(8, 0)], $urandom_range(2, 0), $urandom_range(2, 0), rbit());
        end
        run_instr(6'b111111, 0, 0, 1'b0);
        do_reset(2);
        for (int i = 0; i < 17; i++) run_instr(T_J, 0, 0, 1'b0);
        run_instr(T_R, 0, 0, 1'b0);
        // Store interrupted by reset while waiting in the write state.
        step(P_FETCH, T_SW, 1'b1, 1'b0);
        step(P_DECODE, T_SW, 1'b1, 1'b0);
        step(P_MEMADR, T_SW, 1'b0, 1'b0);
        mem_ready = 1'b0;
        #1;
        check("pre_abort_mem_write", mem_write === 1'b1 && state === 4'd5, int'(mem_write), 1);
        rst_n = 1'b0;
        #1;
        check("async_rst_mem_write", mem_write === 1'b0, int'(mem_write), 0);
        check("async_rst_state", state === 4'd0, int'(state), 0);
        check("async_rst_count", instr_count === 16'd0 && b_instr_count === 4'd0, int'(instr_count), 0);
        @(posedge clk); #1;
        do_reset(2);
        run_instr(T_LW, 0, 1, 1'b0);
        run_instr(6'b010001, 1, 0, 1'b0);
        do_reset(1);
        run_instr(T_ADDI, 0, 0, 1'b0);
        @(posedge clk); #1;
        check("queue_drained", exp_q.size() == 0, exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 The block SHALL have parameter MEM_HANDSHAKE, default 1: 1 = memory states wait for mem_ready; 0 = memory completes in one cycle.
REQ-002 The block SHALL have parameter CNT_W, default 16: width of the retired-instruction counter.
REQ-003 The block SHALL have port clk  input  1  the single clock, rising edge.
REQ-004 The block SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 The block SHALL have port opcode  input  6  instruction[31:26] from the instruction register.
REQ-006 The block SHALL have port zero  input  1  ALU zero flag.
REQ-007 The block SHALL have port mem_ready  input  1  memory access complete; ignored when MEM_HANDSHAKE=0.
REQ-008 The block SHALL have outputs pc_write, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_write and alu_src_a, each 1 bit, with the standard multi-cycle MIPS datapath meaning.
REQ-009 The block SHALL have outputs alu_src_b  2  (00 = B, 01 = 4, 10 = sign-extended immediate, 11 = sign-extended immediate << 2) and pc_src  2  (00 = ALU, 01 = ALUOut, 10 = jump target).
REQ-010 The block SHALL have output alu_op  3  with codes 000 = add, 001 = sub, 010 = funct decode, 011 = and, 100 = or.
REQ-011 The block SHALL have outputs illegal  1  (sticky illegal-opcode flag), state  4  (debug) and instr_count  CNT_W.

Function
REQ-012 The controller SHALL be an FSM with states FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, RTEX=6, RTWB=7, BRANCH=8, IMMEX=9, IMMWB=10, JUMP=11 and TRAP=12.
REQ-013 In FETCH, outputs SHALL be: mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=000, pc_src=00, with ir_write=pc_write=done.
REQ-014 done SHALL equal mem_ready when MEM_HANDSHAKE=1, and 1 otherwise; FETCH SHALL go to DECODE on done and otherwise hold.
REQ-015 In DECODE, the block SHALL drive alu_src_a=0, alu_src_b=11, alu_op=000, latch opcode into op_q, and branch on opcode.
REQ-016 From DECODE, the next state SHALL be: 000000 -> RTEX; 100011 or 101011 -> MEMADR; 000100 or 000101 -> BRANCH; 001000, 001100 or 001101 -> IMMEX; 000010 -> JUMP; any other opcode -> TRAP.
REQ-017 In MEMADR, the block SHALL drive alu_src_a=1, alu_src_b=10, alu_op=000, then go to MEMRD if op_q=lw, else MEMWR.
REQ-018 MEMRD SHALL drive mem_read=1, iord=1 and hold until done, then go to MEMWB.
REQ-019 MEMWB SHALL drive reg_write=1, reg_dst=0, mem_to_reg=1, then go to FETCH.
REQ-020 MEMWR SHALL drive mem_write=1, iord=1 and hold until done, then go to FETCH.
REQ-021 RTEX SHALL drive alu_src_a=1, alu_src_b=00, alu_op=010, then go to RTWB; RTWB SHALL drive reg_write=1, reg_dst=1, mem_to_reg=0, then go to FETCH.
REQ-022 IMMEX SHALL drive alu_src_a=1, alu_src_b=10, with alu_op = 000 for addi, 011 for andi, 100 for ori, selected by op_q.
REQ-023 IMMEX SHALL go to IMMWB; IMMWB SHALL drive reg_write=1, reg_dst=0, mem_to_reg=0, then go to FETCH.
REQ-024 BRANCH SHALL drive alu_src_a=1, alu_src_b=00, alu_op=001, pc_src=01, then go to FETCH.
REQ-025 In BRANCH, pc_write SHALL be (op_q=beq & zero) | (op_q=bne & ~zero).
REQ-026 JUMP SHALL drive pc_src=10, pc_write=1, then go to FETCH.
REQ-027 TRAP SHALL be absorbing until reset, set illegal=1, and drive all enables (pc_write, ir_write, reg_write, mem_read, mem_write) to 0.
REQ-028 Any output not listed for a state SHALL be 0; no output SHALL ever be X.
REQ-029 instr_count SHALL increment by 1 on every transition into FETCH from a non-FETCH state (instruction retired), wrapping modulo 2^CNT_W.
REQ-030 Cycle counts with done=1 SHALL be: R-type 4, lw 5, sw 4, branch 3, imm 4, j 3.
REQ-031 Each cycle mem_ready is low SHALL add one cycle in FETCH, MEMRD or MEMWR.
REQ-032 Outputs SHALL depend on state, plus zero, mem_ready and op_q only where stated above.

Reset
REQ-033 While rst_n=0, the FSM SHALL be in FETCH, with op_q=0, illegal=0 and instr_count=0, asynchronously including mid-instruction.
REQ-034 While rst_n=0, all enables SHALL be 0, including FETCH's mem_read.
REQ-035 After rst_n deasserts, the FSM SHALL start a fetch on the first rising clk edge.

Structure
REQ-036 The state enum, opcode constants (R, LW, SW, BEQ, BNE, ADDI, ANDI, ORI, J) and alu_op codes SHALL reside in a shared package, mips_pkg, reused by the ALU control.
REQ-037 The block SHALL be a single module with no sub-modules: one sequential process for state, op_q, illegal and the counter; one combinational process for next state and outputs.

Verification
REQ-038 The bench SHALL cover: reset, then opcode=000000 with mem_ready=1 -> states 0,1,6,7,0; reg_write=1 only in the RTWB cycle with reg_dst=1; instr_count=1.
REQ-039 The bench SHALL cover: lw with mem_ready low for 2 cycles in MEMRD -> MEMRD held for 3 cycles, mem_read=iord=1 throughout, then MEMWB with mem_to_reg=1.
REQ-040 The bench SHALL cover: beq with zero=0 -> pc_write=0 in BRANCH; bne with zero=0 -> pc_write=1 with pc_src=01.
REQ-041 The bench SHALL cover: andi then ori -> alu_op 011 then 100 in IMMEX; addi -> alu_op 000.
REQ-042 The bench SHALL cover: opcode 111111 -> TRAP, illegal=1, all enables 0 for 10 cycles; rst_n pulse -> FETCH, illegal=0.
REQ-043 The bench SHALL cover: CNT_W=4 with 17 jumps -> instr_count=1 after wrap; rst_n asserted during MEMWR -> mem_write drops to 0 immediately, without waiting for a clock edge.
